// File: rtl/matriz_led_pkg.sv
// Shared constants and state encoding for the column-scanned LED matrix driver.
package matriz_led_pkg;

    localparam int DEF_COLS         = 5;
    localparam int DEF_ROWS         = 7;
    localparam int DEF_DIV          = 4;
    localparam int DEF_BLINK_FRAMES = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Width of a counter spanning 0..n-1; never collapses to zero bits.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matriz_led_varredura_divisor_clk.sv
// Column dwell prescaler: counts 0..DIV-1 and flags the last cycle of each dwell.
module divisor_clk
    import matriz_led_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W = cntWidth(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear || (count_q == LAST)) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST) && !clear;

endmodule

// File: rtl/matriz_led_varredura.sv
// Multiplexed LED matrix scanner: one column at a time, frame-latched pattern,
// optional whole-frame blinking.
module matriz_led_varredura
    import matriz_led_pkg::*;
#(
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    parameter int DIV          = DEF_DIV,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sel_atk,
    input  logic                 blink,
    input  logic [COLS*ROWS-1:0] codigo_map,
    input  logic [COLS*ROWS-1:0] codigo_atk,
    output logic [COLS-1:0]      col,
    output logic [ROWS-1:0]      row,
    output logic                 frame_done
);

    localparam int               IDX_W    = cntWidth(COLS);
    localparam int               BLK_W    = cntWidth(BLINK_FRAMES);
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [COLS-1:0]  COL0     = COLS'(1);

    state_t                 state_q, state_d;
    logic [COLS*ROWS-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [BLK_W-1:0]       blinkCnt_q, blinkCnt_d;
    logic                   blinkPhase_q, blinkPhase_d;
    logic [COLS-1:0]        col_q, col_d;
    logic [ROWS-1:0]        row_q, row_d;
    logic                   frameDone_q, frameDone_d;

    logic                   tick;
    logic                   prescClear;
    logic [COLS*ROWS-1:0]   selPattern;

    assign selPattern = sel_atk ? codigo_atk : codigo_map;
    assign prescClear = (state_q != SCAN) || !en;

    divisor_clk #(
        .DIV(DIV)
    ) uDivisor (
        .clk   (clk),
        .rst   (rst),
        .clear (prescClear),
        .tick  (tick)
    );

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        idx_d        = idx_q;
        blinkCnt_d   = blinkCnt_q;
        blinkPhase_d = blinkPhase_q;
        col_d        = '0;
        row_d        = '0;
        frameDone_d  = 1'b0;

        case (state_q)
            IDLE: begin
                idx_d        = '0;
                blinkCnt_d   = '0;
                blinkPhase_d = 1'b0;
                if (en) begin
                    state_d  = SCAN;
                    shadow_d = selPattern;
                end
            end
            SCAN: begin
                if (!en) begin
                    state_d      = IDLE;
                    idx_d        = '0;
                    blinkCnt_d   = '0;
                    blinkPhase_d = 1'b0;
                end else if (tick) begin
                    if (idx_q == LAST_COL) begin
                        // Only the frame wrap latches a new pattern, so a frame never tears.
                        idx_d       = '0;
                        shadow_d    = selPattern;
                        frameDone_d = 1'b1;
                        if (blinkCnt_q == LAST_BLK) begin
                            blinkCnt_d   = '0;
                            blinkPhase_d = !blinkPhase_q;
                        end else begin
                            blinkCnt_d = blinkCnt_q + 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are built from the next-state view.
        if ((state_d == SCAN) && !(blink && blinkPhase_d)) begin
            col_d = COL0 << idx_d;
            row_d = shadow_d[idx_d*ROWS +: ROWS];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            idx_q        <= '0;
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            frameDone_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            idx_q        <= idx_d;
            blinkCnt_q   <= blinkCnt_d;
            blinkPhase_q <= blinkPhase_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frameDone_q  <= frameDone_d;
        end
    end

    assign col        = col_q;
    assign row        = row_q;
    assign frame_done = frameDone_q;

endmodule

// File: tb/tb_matriz_led_varredura.sv
// Three scanner configurations driven from one stimulus stream and compared
// against a frame/time-based reference model.
module tb_matriz_led_varredura;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        selAtk;
    logic        blink;
    logic [63:0] map64;
    logic [63:0] atk64;

    logic [4:0] colA, colB;
    logic [6:0] rowA, rowB;
    logic [7:0] colC, rowC;
    logic       fdA, fdB, fdC;

    int checks = 0;
    int errors = 0;

    int          mCols [3] = '{5, 5, 8};
    int          mRows [3] = '{7, 7, 8};
    int          mDiv  [3] = '{4, 4, 3};
    int          mBf   [3] = '{8, 2, 3};
    bit          mActive [3];
    int          mT      [3];
    int          mFrame  [3];
    logic [63:0] mShadow [3];
    bit          mFd     [3];

    always #5 clk = ~clk;

    matriz_led_varredura #(.COLS(5), .ROWS(7), .DIV(4), .BLINK_FRAMES(8)) dutA (
        .clk(clk), .rst(rst), .en(en), .sel_atk(selAtk), .blink(blink),
        .codigo_map(map64[34:0]), .codigo_atk(atk64[34:0]),
        .col(colA), .row(rowA), .frame_done(fdA)
    );

    matriz_led_varredura #(.COLS(5), .ROWS(7), .DIV(4), .BLINK_FRAMES(2)) dutB (
        .clk(clk), .rst(rst), .en(en), .sel_atk(selAtk), .blink(blink),
        .codigo_map(map64[34:0]), .codigo_atk(atk64[34:0]),
        .col(colB), .row(rowB), .frame_done(fdB)
    );

    matriz_led_varredura #(.COLS(8), .ROWS(8), .DIV(3), .BLINK_FRAMES(3)) dutC (
        .clk(clk), .rst(rst), .en(en), .sel_atk(selAtk), .blink(blink),
        .codigo_map(map64), .codigo_atk(atk64),
        .col(colC), .row(rowC), .frame_done(fdC)
    );

    function automatic logic [63:0] maskPat(input int k, input logic [63:0] p);
        int n;
        n = mCols[k] * mRows[k];
        if (n >= 64) return p;
        return p & ((64'd1 << n) - 64'd1);
    endfunction

    // Reference: position in the frame is a plain cycle count; column = t / DIV.
    task automatic modelEdge();
        for (int k = 0; k < 3; k++) begin
            mFd[k] = 1'b0;
            if (rst) begin
                mActive[k] = 1'b0;
                mT[k]      = 0;
                mFrame[k]  = 0;
                mShadow[k] = '0;
            end else if (!en) begin
                mActive[k] = 1'b0;
                mT[k]      = 0;
                mFrame[k]  = 0;
            end else if (!mActive[k]) begin
                mActive[k] = 1'b1;
                mT[k]      = 0;
                mFrame[k]  = 0;
                mShadow[k] = maskPat(k, selAtk ? atk64 : map64);
            end else begin
                mT[k]++;
                if (mT[k] == mCols[k] * mDiv[k]) begin
                    mT[k]      = 0;
                    mFrame[k]++;
                    mShadow[k] = maskPat(k, selAtk ? atk64 : map64);
                    mFd[k]     = 1'b1;
                end
            end
        end
    endtask

    task automatic checkOutput(input int k, input logic [63:0] aCol,
                               input logic [63:0] aRow, input logic aFd);
        logic [63:0] expCol, expRow;
        int c;
        expCol = '0;
        expRow = '0;
        if (mActive[k] && !(blink && (((mFrame[k] / mBf[k]) % 2) == 1))) begin
            c      = mT[k] / mDiv[k];
            expCol = 64'd1 << c;
            expRow = (mShadow[k] >> (c * mRows[k])) & ((64'd1 << mRows[k]) - 64'd1);
        end
        checks++;
        assert (aCol === expCol) else begin
            errors++;
            $error("[TB] FAIL col dut%0d t=%0t got %h want %h", k, $time, aCol, expCol);
        end
        checks++;
        assert (aRow === expRow) else begin
            errors++;
            $error("[TB] FAIL row dut%0d t=%0t got %h want %h", k, $time, aRow, expRow);
        end
        checks++;
        assert (aFd === mFd[k]) else begin
            errors++;
            $error("[TB] FAIL frame_done dut%0d t=%0t got %b want %b", k, $time, aFd, mFd[k]);
        end
        checks++;
        assert ($onehot0(aCol)) else begin
            errors++;
            $error("[TB] FAIL onehot dut%0d t=%0t got %h want at most one bit", k, $time, aCol);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            modelEdge();
            #1;
            checkOutput(0, 64'(colA), 64'(rowA), fdA);
            checkOutput(1, 64'(colB), 64'(rowB), fdB);
            checkOutput(2, 64'(colC), 64'(rowC), fdC);
        end
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        selAtk = 1'b0;
        blink  = 1'b0;
        map64  = {$urandom, $urandom};
        atk64  = {$urandom, $urandom};
        applyStimulus(2);

        // Known pattern on the 5x7 instances, two full frames.
        rst   = 1'b0;
        map64 = {29'($urandom), 35'h1_2345_6789};
        en    = 1'b1;
        applyStimulus(40);

        // Pattern and select change mid-frame take effect only at the next frame.
        applyStimulus(9);
        selAtk = 1'b1;
        atk64  = {$urandom, $urandom};
        map64  = {$urandom, $urandom};
        applyStimulus(45);

        blink = 1'b1;
        applyStimulus(120);

        // Drop enable partway through a frame, then restart.
        blink = 1'b0;
        applyStimulus(13);
        en = 1'b0;
        applyStimulus(3);
        en = 1'b1;
        applyStimulus(30);

        // Reset while the BLINK_FRAMES=2 instance is in its blank phase.
        en = 1'b0;
        applyStimulus(1);
        en    = 1'b1;
        blink = 1'b1;
        applyStimulus(47);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        applyStimulus(25);

        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 24) != 0);
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 15) == 0) blink  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) == 0)  selAtk = ~selAtk;
            if ($urandom_range(0, 4) == 0)  map64  = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0)  atk64  = {$urandom, $urandom};
            applyStimulus(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
